// File: rtl/obf_logic_arb_pkg.sv
// Shared opcode constants and FSM state type for the obf_logic_arb round-robin logic unit.
package obf_logic_arb_pkg;

    localparam logic OP_AND = 1'b0;
    localparam logic OP_XOR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/obf_logic_arb_if.sv
// Requester/consumer bundle for obf_logic_arb; res_par_o exists only when OBF_LOGIC_ARB_PARITY_EN is defined.
interface obf_logic_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    localparam int IDW = $clog2(NREQ);

    // Handshakes: req_i[k] is a level held until gnt_o[k] pulses for one cycle;
    // a result transfers on the cycle where res_valid_o && res_ready_i are both high.
    logic [NREQ-1:0]   req_i;
    logic [NREQ-1:0]   op_i;
    logic [NREQ*W-1:0] a_i;
    logic [NREQ*W-1:0] b_i;
    logic [NREQ-1:0]   gnt_o;
    logic [W-1:0]      res_o;
    logic [IDW-1:0]    res_id_o;
    logic              res_valid_o;
    logic              res_ready_i;
`ifdef OBF_LOGIC_ARB_PARITY_EN
    logic              res_par_o;

    modport slave (
        input  req_i, op_i, a_i, b_i, res_ready_i,
        output gnt_o, res_o, res_id_o, res_valid_o, res_par_o
    );
    modport master (
        output req_i, op_i, a_i, b_i, res_ready_i,
        input  gnt_o, res_o, res_id_o, res_valid_o, res_par_o
    );
`else
    modport slave (
        input  req_i, op_i, a_i, b_i, res_ready_i,
        output gnt_o, res_o, res_id_o, res_valid_o
    );
    modport master (
        output req_i, op_i, a_i, b_i, res_ready_i,
        input  gnt_o, res_o, res_id_o, res_valid_o
    );
`endif
endinterface

// File: rtl/obf_rr_pick.sv
// Combinational round-robin picker: first set request found scanning upward from ptr_i+1 with wrap.
module obf_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            valid_o,
    output logic [IDW-1:0]  idx_o
);
    logic [IDW-1:0] cand;

    // Scan farthest offset first so the nearest requester after ptr_i overrides.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = IDW'((int'(ptr_i) + off) % NREQ);
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/obf_logic_arb.sv
// Round-robin sequencer sharing one registered AND/XOR unit among NREQ requesters.
// Optional parity output enabled by OBF_LOGIC_ARB_PARITY_EN.
module obf_logic_arb
    import obf_logic_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    obf_logic_arb_if.slave     bus,
    output state_t             state_o
);
    localparam int IDW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic            op_q, op_d, valid_q, valid_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;

    obf_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        valid_d = valid_q;
        gnt_d   = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = CALC;
                    gnt_d   = NREQ'(1) << pick_idx;
                    ptr_d   = pick_idx;
                    id_d    = pick_idx;
                    a_d     = bus.a_i[int'(pick_idx)*W +: W];
                    b_d     = bus.b_i[int'(pick_idx)*W +: W];
                    op_d    = bus.op_i[pick_idx];
                end
            end
            CALC: begin
                res_d   = (op_q == OP_XOR) ? (a_q ^ b_q) : (a_q & b_q);
                valid_d = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (valid_q && bus.res_ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            res_q   <= '0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef OBF_LOGIC_ARB_PARITY_EN
    logic par_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            par_q <= 1'b0;
        end else if (state_q == CALC) begin
            par_q <= ^res_d;
        end
    end

    assign bus.res_par_o = par_q;
`endif

    assign bus.gnt_o       = gnt_q;
    assign bus.res_o       = res_q;
    assign bus.res_id_o    = id_q;
    assign bus.res_valid_o = valid_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_obf_logic_arb.sv
// Directed bench for obf_logic_arb: reset, AND/XOR, fairness, backpressure and reset mid-transaction.
module tb_obf_logic_arb;
    import obf_logic_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic   clk  = 1'b0;
    logic   rstn = 1'b0;
    state_t state;
    int     checks   = 0;
    int     failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_res;

    obf_logic_arb_if #(.NREQ(NREQ), .W(W)) bus();

    obf_logic_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .bus     (bus.slave),
        .state_o (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_opnd(input int k, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_i[k]        = op;
        bus.a_i[k*W +: W]  = a;
        bus.b_i[k*W +: W]  = b;
    endtask

    initial begin
        // Reset held with random inputs
        bus.req_i       = 4'($urandom_range(0, 15));
        bus.op_i        = 4'($urandom_range(0, 15));
        bus.a_i         = 32'($urandom);
        bus.b_i         = 32'($urandom);
        bus.res_ready_i = 1'($urandom_range(0, 1));
        repeat (3) tick();
        check("rst_gnt",   32'(bus.gnt_o), 32'h0);
        check("rst_valid", 32'(bus.res_valid_o), 32'h0);
        check("rst_res",   32'(bus.res_o), 32'h0);
        check("rst_id",    32'(bus.res_id_o), 32'h0);
        check("rst_state", 32'(state), 32'(IDLE));
        bus.req_i = '0;
        bus.res_ready_i = 1'b1;
        rstn = 1'b1;
        tick();

        // AND on requester 1
        set_opnd(1, OP_AND, 8'hF0, 8'h3C);
        bus.req_i = 4'b0010;
        tick();
        check("and_gnt",   32'(bus.gnt_o), 32'h2);
        check("and_state", 32'(state), 32'(CALC));
        bus.req_i = '0;
        tick();
        check("and_valid", 32'(bus.res_valid_o), 32'h1);
        check("and_res",   32'(bus.res_o), 32'h30);
        check("and_id",    32'(bus.res_id_o), 32'h1);
        check("and_gnt_n2", 32'(bus.gnt_o), 32'h0);
        tick();
        check("and_valid_drop", 32'(bus.res_valid_o), 32'h0);

        // XOR on requester 1
        set_opnd(1, OP_XOR, 8'hF0, 8'h3C);
        bus.req_i = 4'b0010;
        tick();
        check("xor_gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = '0;
        tick();
        check("xor_valid", 32'(bus.res_valid_o), 32'h1);
        check("xor_res",   32'(bus.res_o), 32'hCC);
        check("xor_id",    32'(bus.res_id_o), 32'h1);
`ifdef OBF_LOGIC_ARB_PARITY_EN
        check("xor_par",   32'(bus.res_par_o), 32'h0);
`endif
        tick();
        check("xor_valid_drop", 32'(bus.res_valid_o), 32'h0);

        // Fairness from a fresh reset: all four requesting
        rstn = 1'b0;
        for (int k = 0; k < NREQ; k++) set_opnd(k, OP_XOR, W'(k), 8'hFF);
        tick();
        exp_q = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};
        bus.req_i = 4'b1111;
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fair_gnt", 32'(bus.gnt_o), 32'(4'b0001 << (i % NREQ)));
            tick();
            exp_res = exp_q.pop_front();
            check("fair_valid", 32'(bus.res_valid_o), 32'h1);
            check("fair_res",   32'(bus.res_o), 32'(exp_res));
            check("fair_id",    32'(bus.res_id_o), 32'(i % NREQ));
            tick();
            check("fair_idle", 32'(bus.res_valid_o), 32'h0);
        end
        bus.req_i = '0;
        check("fair_q_empty", 32'(exp_q.size()), 32'h0);

        // Backpressure: requester 2 stalls for 5 cycles while everyone requests
        set_opnd(2, OP_XOR, 8'h5A, 8'h0F);
        set_opnd(3, OP_AND, 8'h33, 8'h0F);
        bus.res_ready_i = 1'b0;
        bus.req_i = 4'b0100;
        tick();
        check("bp_gnt", 32'(bus.gnt_o), 32'h4);
        bus.req_i = 4'b1111;
        tick();
        check("bp_valid", 32'(bus.res_valid_o), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus.res_valid_o), 32'h1);
            check("bp_hold_res",   32'(bus.res_o), 32'h55);
            check("bp_hold_id",    32'(bus.res_id_o), 32'h2);
            check("bp_hold_gnt",   32'(bus.gnt_o), 32'h0);
        end
        bus.res_ready_i = 1'b1;
        bus.req_i = 4'b1000;
        tick();
        check("bp_release_valid", 32'(bus.res_valid_o), 32'h0);
        check("bp_release_gnt",   32'(bus.gnt_o), 32'h0);
        tick();
        check("bp_next_gnt", 32'(bus.gnt_o), 32'h8);
        bus.req_i = '0;
        tick();
        check("bp_next_res", 32'(bus.res_o), 32'h03);
        check("bp_next_id",  32'(bus.res_id_o), 32'h3);
        tick();
        check("bp_next_idle", 32'(bus.res_valid_o), 32'h0);

        // Reset while a result is waiting
        set_opnd(1, OP_XOR, 8'hF0, 8'h3C);
        bus.res_ready_i = 1'b0;
        bus.req_i = 4'b0010;
        tick();
        check("rw_gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = '0;
        tick();
        check("rw_valid_pre", 32'(bus.res_valid_o), 32'h1);
        rstn = 1'b0;
        #1;
        check("rw_valid_async", 32'(bus.res_valid_o), 32'h0);
        check("rw_res_async",   32'(bus.res_o), 32'h0);
        check("rw_state_async", 32'(state), 32'(IDLE));
        tick();
        bus.req_i = 4'b1000;
        bus.res_ready_i = 1'b1;
        rstn = 1'b1;
        tick();
        check("rw_gnt_after", 32'(bus.gnt_o), 32'h8);
        bus.req_i = '0;
        tick();
        check("rw_res_after", 32'(bus.res_o), 32'h03);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
